// File: rtl/id_decode_ctrl_pkg.sv
// Shared types and constants for the decode-stage controller: opcode map,
// skid-buffer state encoding and the buffered entry layout.
package id_decode_ctrl_pkg;

  localparam int WIDTH = 64;

  localparam logic [6:0] r_type_opcode     = 7'b0110011;
  localparam logic [6:0] rw_type_opcode    = 7'b0111011;
  localparam logic [6:0] i_type_opcode     = 7'b0010011;
  localparam logic [6:0] iw_type_opcode    = 7'b0011011;
  localparam logic [6:0] l_type_opcode     = 7'b0000011;
  localparam logic [6:0] s_type_opcode     = 7'b0100011;
  localparam logic [6:0] b_type_opcode     = 7'b1100011;
  localparam logic [6:0] jal_type_opcode   = 7'b1101111;
  localparam logic [6:0] jalr_type_opcode  = 7'b1100111;
  localparam logic [6:0] lui_type_opcode   = 7'b0110111;
  localparam logic [6:0] auipc_type_opcode = 7'b0010111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Bit order matches the {illegal,u,j,b,s,l,i,r} vector the extender expects.
  typedef struct packed {
    logic illegal;
    logic u;
    logic j;
    logic b;
    logic s;
    logic l;
    logic i;
    logic r;
  } cls_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
    cls_t             cls;
  } entry_t;

endpackage

// File: rtl/id_decode_ctrl_if.sv
// IF->ID and ID->EX handshake bundle; slave is the decode controller's view,
// master is the surrounding pipeline (fetch driving, execute consuming).
interface id_decode_ctrl_if;
  import id_decode_ctrl_pkg::*;

  logic             if_valid;
  logic [31:0]      if_instr;
  logic [WIDTH-1:0] if_pc;
  logic             id_ready;
  logic             flush;
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_instr;
  logic [WIDTH-1:0] ex_pc;
  logic             ex_r_type;
  logic             ex_i_type;
  logic             ex_l_type;
  logic             ex_s_type;
  logic             ex_b_type;
  logic             ex_j_type;
  logic             ex_u_type;
  logic             ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_instr, ex_pc,
           ex_r_type, ex_i_type, ex_l_type, ex_s_type,
           ex_b_type, ex_j_type, ex_u_type, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_instr, ex_pc,
           ex_r_type, ex_i_type, ex_l_type, ex_s_type,
           ex_b_type, ex_j_type, ex_u_type, ex_illegal
  );

endinterface

// File: rtl/id_decode_ctrl_opcode_classify.sv
// Opcode -> one-hot {illegal,u,j,b,s,l,i,r}; purely combinational, no state,
// no handshake. Unrecognised opcodes raise only the illegal bit.
module opcode_classify
  import id_decode_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_t       cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      r_type_opcode,   rw_type_opcode:    cls_o.r = 1'b1;
      i_type_opcode,   iw_type_opcode:    cls_o.i = 1'b1;
      l_type_opcode:                      cls_o.l = 1'b1;
      s_type_opcode:                      cls_o.s = 1'b1;
      b_type_opcode:                      cls_o.b = 1'b1;
      jal_type_opcode, jalr_type_opcode:  cls_o.j = 1'b1;
      lui_type_opcode, auipc_type_opcode: cls_o.u = 1'b1;
      default:                            cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_decode_ctrl.sv
// Decode-stage controller: classifies IF words and presents them to EX one cycle
// later; a head+skid pair keeps id_ready registered, flush empties both entries.
module id_decode_ctrl
  import id_decode_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  id_decode_ctrl_if.slave bus
);

  state_e state_q;
  logic   id_ready_q;
  logic   ex_valid_q;
  entry_t head_q;
  entry_t skid_q;
  entry_t in_entry;
  cls_t   in_cls;
  logic   accept;
  logic   consume;

  opcode_classify u_classify (
    .opcode_i (bus.if_instr[6:0]),
    .cls_o    (in_cls)
  );

  always_comb begin
    in_entry       = '0;
    in_entry.instr = bus.if_instr;
    in_entry.pc    = bus.if_pc;
    in_entry.cls   = in_cls;
  end

  assign accept  = bus.if_valid && id_ready_q;
  assign consume = ex_valid_q && bus.ex_ready;

  // Flags track entry validity; instr/pc are left stale once an entry drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      id_ready_q <= 1'b1;
      ex_valid_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      state_q    <= ST_EMPTY;
      id_ready_q <= 1'b1;
      ex_valid_q <= 1'b0;
      head_q.cls <= '0;
      skid_q.cls <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_q     <= in_entry;
            ex_valid_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            head_q <= in_entry;
          end else if (accept) begin
            skid_q     <= in_entry;
            id_ready_q <= 1'b0;
            state_q    <= ST_TWO;
          end else if (consume) begin
            head_q.cls <= '0;
            ex_valid_q <= 1'b0;
            state_q    <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            head_q     <= skid_q;
            skid_q.cls <= '0;
            id_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          head_q.cls <= '0;
          skid_q.cls <= '0;
          id_ready_q <= 1'b1;
          ex_valid_q <= 1'b0;
          state_q    <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.id_ready   = id_ready_q;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_instr   = head_q.instr;
  assign bus.ex_pc      = head_q.pc;
  assign bus.ex_r_type  = head_q.cls.r;
  assign bus.ex_i_type  = head_q.cls.i;
  assign bus.ex_l_type  = head_q.cls.l;
  assign bus.ex_s_type  = head_q.cls.s;
  assign bus.ex_b_type  = head_q.cls.b;
  assign bus.ex_j_type  = head_q.cls.j;
  assign bus.ex_u_type  = head_q.cls.u;
  assign bus.ex_illegal = head_q.cls.illegal;

endmodule
